// File: rtl/fpu_apu_arbiter.sv
// fpu_apu_arbiter: shares one FPU (APU-style handshake) between NUM_REQ
// requesters. Requesters are issued round-robin, and a tag FIFO records the
// owner of every in-flight operation so that each result is steered back to it.
// Issue and response paths are combinational; only err_o is registered.
// Optional build macro FPU_ARB_DIVSQRT_SERIAL_EN: div/sqrt ops issue only into
// an empty pipeline and block all other issue until their result returns.
module fpu_apu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DEPTH   = 2,
   parameter int FLEN    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ*6-1:0]        req_op_i,
   input  logic [NUM_REQ*3*FLEN-1:0]   req_operands_i,
   input  logic [NUM_REQ*3-1:0]        req_rm_i,
   input  logic [NUM_REQ-1:0]          req_divsqrt_i,
   output logic [NUM_REQ-1:0]          rsp_valid_o,
   output logic [FLEN-1:0]             rsp_result_o,
   output logic [4:0]                  rsp_fflags_o,
   output logic                        apu_req_o,
   input  logic                        apu_gnt_i,
   output logic [5:0]                  apu_op_o,
   output logic [3*FLEN-1:0]           apu_operands_o,
   output logic [14:0]                 apu_flags_o,
   input  logic                        apu_rvalid_i,
   input  logic [FLEN-1:0]             apu_result_i,
   input  logic [4:0]                  apu_rflags_i,
   output logic                        busy_o,
   output logic                        err_o
);

   localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

   // registered state
   state_t             r_state;
   logic [SEL_W-1:0]   r_lock_sel;
   logic [SEL_W-1:0]   r_rr;
   logic [SEL_W-1:0]   r_tag_sel [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_err;

   // combinational nets
   int                 w_idx;
   logic               w_any;
   logic [SEL_W-1:0]   w_rr_sel;
   logic [SEL_W-1:0]   w_sel;
   logic               w_empty;
   logic               w_full;
   logic               w_block;
   logic               w_issue_allowed;
   logic               w_issue;
   logic               w_bypass;
   logic               w_push;
   logic               w_pop;
   logic               w_spurious;
   logic [SEL_W-1:0]   w_head_sel;

   // wrap-around increment for FIFO pointers (DEPTH need not fill PTR_W)
   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_head_sel = r_tag_sel[r_rd_ptr];

   // round-robin pick: first valid requester at or after r_rr
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_rr_sel = r_rr;
      w_any    = 1'b0;
      w_idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = (int'(r_rr) + k) % NUM_REQ;
         if (req_valid_i[w_idx]) begin
            w_rr_sel = SEL_W'(w_idx);
            w_any    = 1'b1;
         end
      end
   end

   // a held request keeps its locked owner regardless of new arrivals
   assign w_sel = (r_state == ST_HOLD) ? r_lock_sel : w_rr_sel;

`ifdef FPU_ARB_DIVSQRT_SERIAL_EN
   logic r_tag_ds [DEPTH];

   // div/sqrt needs an empty pipe, and an in-flight div/sqrt (always alone
   // in the FIFO) stalls everything until it pops
   assign w_block = !w_empty && (r_tag_ds[r_rd_ptr] || req_divsqrt_i[w_rr_sel]);

   // divsqrt flag per tag entry, written alongside the owner
   always_ff @(posedge clk) begin
      if (w_push) r_tag_ds[r_wr_ptr] <= req_divsqrt_i[w_sel];
   end
`else
   logic w_unused_divsqrt;
   assign w_unused_divsqrt = ^req_divsqrt_i;
   assign w_block          = 1'b0;
`endif

   assign w_issue_allowed = (r_state == ST_IDLE) && w_any && !w_full && !w_block;
   assign apu_req_o       = !rst && ((r_state == ST_HOLD) || w_issue_allowed);
   assign w_issue         = apu_req_o && apu_gnt_i;

   // a result in the issue cycle with nothing queued belongs to the issuer
   assign w_bypass   = w_issue && w_empty && apu_rvalid_i;
   assign w_push     = w_issue && !w_bypass;
   assign w_pop      = apu_rvalid_i && !w_empty;
   assign w_spurious = apu_rvalid_i && w_empty && !w_issue;

   // payload mux toward the FPU
   assign apu_op_o       = rst ? '0 : req_op_i[int'(w_sel)*6 +: 6];
   assign apu_operands_o = rst ? '0 : req_operands_i[int'(w_sel)*3*FLEN +: 3*FLEN];
   assign apu_flags_o    = rst ? '0 : {12'b0, req_rm_i[int'(w_sel)*3 +: 3]};

   // ready pulses only for the requester issuing this cycle
   always_comb begin
      req_ready_o = '0;
      if (w_issue) req_ready_o[w_sel] = 1'b1;
   end

   // steer the response valid to the FIFO head, or to the issuer on bypass
   always_comb begin
      rsp_valid_o = '0;
      if (!rst) begin
         if (!w_empty)      rsp_valid_o[w_head_sel] = apu_rvalid_i;
         else if (w_bypass) rsp_valid_o[w_sel]      = 1'b1;
      end
   end

   assign rsp_result_o = rst ? '0 : apu_result_i;
   assign rsp_fflags_o = rst ? '0 : apu_rflags_i;
   assign busy_o       = !w_empty || (r_state == ST_HOLD);
   assign err_o        = r_err;

   // issue FSM and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_lock_sel <= '0;
         r_rr       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         case (r_state)
            ST_IDLE: if (w_issue_allowed && !apu_gnt_i) begin
               r_lock_sel <= w_rr_sel;
               r_state    <= ST_HOLD;
            end
            ST_HOLD: if (apu_gnt_i) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         if (w_issue)
            r_rr <= (w_sel == SEL_W'(NUM_REQ - 1)) ? '0 : w_sel + SEL_W'(1);
      end
   end

   // tag FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // tag storage: owner index of each in-flight op
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; entries are only read once pushed, so reset costs logic for nothing.
      if (w_push) r_tag_sel[r_wr_ptr] <= w_sel;
   end

   // sticky error: a result arrived that nobody owns
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_err <= 1'b0;
      else if (w_spurious) r_err <= 1'b1;
   end

endmodule

// File: tb/tb_fpu_apu_arbiter.sv
// Self-checking bench for fpu_apu_arbiter (NUM_REQ=2, DEPTH=2, FLEN=32).
// Cycle vectors are table-driven; expected response owners come from a
// scoreboard queue filled at issue and drained on each FPU result.
module tb_fpu_apu_arbiter;

   localparam logic [5:0]  OP0  = 6'h05;
   localparam logic [5:0]  OP1  = 6'h0A;
   localparam logic [2:0]  RM0  = 3'd1;
   localparam logic [2:0]  RM1  = 3'd3;
   localparam logic [95:0] OPS0 = {32'h11111111, 32'h22222222, 32'h33333333};
   localparam logic [95:0] OPS1 = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};

   logic         clk;
   logic         rst;
   logic [1:0]   req_valid_i;
   logic [1:0]   req_ready_o;
   logic [11:0]  req_op_i;
   logic [191:0] req_operands_i;
   logic [5:0]   req_rm_i;
   logic [1:0]   req_divsqrt_i;
   logic [1:0]   rsp_valid_o;
   logic [31:0]  rsp_result_o;
   logic [4:0]   rsp_fflags_o;
   logic         apu_req_o;
   logic         apu_gnt_i;
   logic [5:0]   apu_op_o;
   logic [95:0]  apu_operands_o;
   logic [14:0]  apu_flags_o;
   logic         apu_rvalid_i;
   logic [31:0]  apu_result_i;
   logic [4:0]   apu_rflags_i;
   logic         busy_o;
   logic         err_o;

   fpu_apu_arbiter #(.NUM_REQ(2), .DEPTH(2), .FLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_op_i       (req_op_i),
      .req_operands_i (req_operands_i),
      .req_rm_i       (req_rm_i),
      .req_divsqrt_i  (req_divsqrt_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_result_o   (rsp_result_o),
      .rsp_fflags_o   (rsp_fflags_o),
      .apu_req_o      (apu_req_o),
      .apu_gnt_i      (apu_gnt_i),
      .apu_op_o       (apu_op_o),
      .apu_operands_o (apu_operands_o),
      .apu_flags_o    (apu_flags_o),
      .apu_rvalid_i   (apu_rvalid_i),
      .apu_result_i   (apu_result_i),
      .apu_rflags_i   (apu_rflags_i),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  v;      // req_valid_i
      logic [1:0]  ds;     // req_divsqrt_i
      logic        g;      // apu_gnt_i
      logic        rv;     // apu_rvalid_i
      logic [31:0] res;    // apu_result_i
      logic [1:0]  ready;  // expected req_ready_o
      logic        req;    // expected apu_req_o
      logic [5:0]  op;     // expected apu_op_o (checked when req)
      logic        busy;   // expected busy_o
      logic        err;    // expected err_o
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   int owner_q[$];

   vec_t tbl  [24];
   vec_t stbl [8];

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] ds, input logic g,
                               input logic rv, input logic [31:0] res, input logic [1:0] ready,
                               input logic req, input logic [5:0] op, input logic busy,
                               input logic err);
      vec_t r;
      r.v = v; r.ds = ds; r.g = g; r.rv = rv; r.res = res;
      r.ready = ready; r.req = req; r.op = op; r.busy = busy; r.err = err;
      return r;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drive one cycle of stimulus, update the scoreboard, compare at negedge
   task automatic run_row(input string tag, input vec_t r);
      logic [1:0]  exp_rsp;
      logic [95:0] exp_ops;
      logic [2:0]  exp_rm;
      int          own;
      req_valid_i   = r.v;
      req_divsqrt_i = r.ds;
      apu_gnt_i     = r.g;
      apu_rvalid_i  = r.rv;
      apu_result_i  = r.res;
      apu_rflags_i  = r.res[4:0] ^ 5'h15;
      if (r.ready != 2'b00) owner_q.push_back(r.ready[1] ? 1 : 0);
      exp_rsp = 2'b00;
      if (r.rv && owner_q.size() > 0) begin
         own     = owner_q.pop_front();
         exp_rsp = (own == 1) ? 2'b10 : 2'b01;
      end
      @(negedge clk);
      check({tag, ".ready"},   req_ready_o, r.ready);
      check({tag, ".apu_req"}, apu_req_o,   r.req);
      if (r.req) begin
         exp_ops = (r.op == OP1) ? OPS1 : OPS0;
         exp_rm  = (r.op == OP1) ? RM1  : RM0;
         check({tag, ".op"},       apu_op_o,       r.op);
         check({tag, ".operands"}, apu_operands_o, exp_ops);
         check({tag, ".flags"},    apu_flags_o,    {12'b0, exp_rm});
      end
      check({tag, ".rsp_valid"}, rsp_valid_o, exp_rsp);
      if (r.rv) begin
         check({tag, ".result"}, rsp_result_o, r.res);
         check({tag, ".fflags"}, rsp_fflags_o, r.res[4:0] ^ 5'h15);
      end
      check({tag, ".busy"}, busy_o, r.busy);
      check({tag, ".err"},  err_o,  r.err);
      @(posedge clk); #1;
   endtask

   // assert reset with live-looking inputs, confirm quiet outputs, release
   task automatic do_reset(input string tag);
      req_valid_i  = 2'b01;
      apu_gnt_i    = 1'b1;
      apu_rvalid_i = 1'b1;
      rst          = 1'b1;
      #1;
      check({tag, ".apu_req"},   apu_req_o,   1'b0);
      check({tag, ".ready"},     req_ready_o, 2'b00);
      check({tag, ".rsp_valid"}, rsp_valid_o, 2'b00);
      check({tag, ".busy"},      busy_o,      1'b0);
      check({tag, ".err"},       err_o,       1'b0);
      req_valid_i  = 2'b00;
      apu_gnt_i    = 1'b0;
      apu_rvalid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      owner_q.delete();
   endtask

   initial begin
      rst            = 1'b1;
      req_valid_i    = '0;
      req_divsqrt_i  = '0;
      apu_gnt_i      = 1'b0;
      apu_rvalid_i   = 1'b0;
      apu_result_i   = '0;
      apu_rflags_i   = '0;
      req_op_i       = {OP1, OP0};
      req_operands_i = {OPS1, OPS0};
      req_rm_i       = {RM1, RM0};

      //              v      ds     g     rv    res           ready  req   op    busy  err
      // round-robin with back-to-back results
      tbl[0]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, OP0,  1'b0, 1'b0);
      tbl[1]  = mk(2'b11, 2'b00, 1'b1, 1'b1, 32'h3F800000, 2'b10, 1'b1, OP1,  1'b1, 1'b0);
      tbl[2]  = mk(2'b11, 2'b00, 1'b1, 1'b1, 32'h40000000, 2'b01, 1'b1, OP0,  1'b1, 1'b0);
      tbl[3]  = mk(2'b11, 2'b00, 1'b1, 1'b1, 32'h40400000, 2'b10, 1'b1, OP1,  1'b1, 1'b0);
      tbl[4]  = mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h40800000, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      tbl[5]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b0, 1'b0);
      // FIFO full: two issues, stall (even with a pop), third issue after
      tbl[6]  = mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, OP1,  1'b0, 1'b0);
      tbl[7]  = mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, OP1,  1'b1, 1'b0);
      tbl[8]  = mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      tbl[9]  = mk(2'b10, 2'b00, 1'b1, 1'b1, 32'h40A00000, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      tbl[10] = mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, OP1,  1'b1, 1'b0);
      tbl[11] = mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h40C00000, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      tbl[12] = mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h40E00000, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      // zero-latency bypass, then confirm nothing was queued
      tbl[13] = mk(2'b01, 2'b00, 1'b1, 1'b1, 32'h41000000, 2'b01, 1'b1, OP0,  1'b0, 1'b0);
      tbl[14] = mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b0, 1'b0);
      // grant withheld 3 cycles: req1 locked while req0 arrives
      tbl[15] = mk(2'b10, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, OP1,  1'b0, 1'b0);
      tbl[16] = mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, OP1,  1'b1, 1'b0);
      tbl[17] = mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, OP1,  1'b1, 1'b0);
      tbl[18] = mk(2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, OP1,  1'b1, 1'b0);
      tbl[19] = mk(2'b01, 2'b00, 1'b1, 1'b1, 32'h41100000, 2'b01, 1'b1, OP0,  1'b1, 1'b0);
      tbl[20] = mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h41200000, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      tbl[21] = mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b0, 1'b0);
      // spurious result sets the sticky error one cycle later
      tbl[22] = mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, 6'h0, 1'b0, 1'b0);
      tbl[23] = mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b0, 1'b1);

      // serialised div/sqrt: req0 div (latency 5), req1 add waits for it
      stbl[0] = mk(2'b11, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, OP0,  1'b0, 1'b0);
      stbl[1] = mk(2'b10, 2'b01, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      stbl[2] = mk(2'b10, 2'b01, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      stbl[3] = mk(2'b10, 2'b01, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      stbl[4] = mk(2'b10, 2'b01, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      stbl[5] = mk(2'b10, 2'b01, 1'b1, 1'b1, 32'h40490FDB, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);
      stbl[6] = mk(2'b10, 2'b01, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, OP1,  1'b0, 1'b0);
      stbl[7] = mk(2'b00, 2'b01, 1'b0, 1'b1, 32'h3FC00000, 2'b00, 1'b0, 6'h0, 1'b1, 1'b0);

      do_reset("reset0");
      for (int i = 0; i < 24; i++) run_row($sformatf("row%0d", i), tbl[i]);

      // reset clears the sticky error
      do_reset("reset_err");

      // reset with a tag in flight: the late result is unowned
      run_row("mid_issue", mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1, OP0, 1'b0, 1'b0));
      do_reset("reset_mid");
      run_row("late_rsp",  mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h3F800000, 2'b00, 1'b0, 6'h0, 1'b0, 1'b0));
      run_row("late_err",  mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 6'h0, 1'b0, 1'b1));

`ifdef FPU_ARB_DIVSQRT_SERIAL_EN
      do_reset("reset_ds");
      for (int i = 0; i < 8; i++) run_row($sformatf("ds%0d", i), stbl[i]);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fpu_apu_arbiter.md
# fpu_apu_arbiter

- Shares the single FPU (APU interface: 3 × 32-bit operands, 6-bit op, 15-bit flags, 5-bit fflags) between `NUM_REQ` requesters, e.g. core issue port and debug/accelerator port.
- Issue order is round-robin fair.
- Up to `DEPTH` operations may be in flight; a tag FIFO records the owner of each one and steers each result back to that owner.
- Sits between the requesters and the FPU wrapper.

## Interface
Parameters:
- `NUM_REQ`, 2: requester count (2..4).
- `DEPTH`, 2: max in-flight ops, power of 2 (1..8).
- `FLEN`, 32: operand/result width.

Ports (per-requester buses are packed, requester i at slice i):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  request valid.
- `req_ready_o`  out  NUM_REQ  request accepted this cycle.
- `req_op_i`  in  NUM_REQ×6  FPU opcode.
- `req_operands_i`  in  NUM_REQ×3×FLEN  operands a,b,c.
- `req_rm_i`  in  NUM_REQ×3  rounding mode.
- `req_divsqrt_i`  in  NUM_REQ  op uses the div/sqrt unit.
- `rsp_valid_o`  out  NUM_REQ  result valid for requester i.
- `rsp_result_o`  out  FLEN  result, shared by all requesters.
- `rsp_fflags_o`  out  5  exception flags, shared.
- `apu_req_o`  out  1  request to FPU.
- `apu_gnt_i`  in  1  FPU grant.
- `apu_op_o`  out  6  opcode to FPU.
- `apu_operands_o`  out  3×FLEN  operands to FPU.
- `apu_flags_o`  out  15  `[2:0]` = rm, `[14:3]` = 0.
- `apu_rvalid_i`  in  1  FPU result valid.
- `apu_result_i`  in  FLEN  FPU result.
- `apu_rflags_i`  in  5  FPU fflags.
- `busy_o`  out  1  FIFO non-empty or FSM in HOLD.
- `err_o`  out  1  sticky: `apu_rvalid_i` arrived with no owner.

## Operation
Eligibility and selection:
- Requester i is eligible when `req_valid_i[i]` = 1.
- Round-robin pointer `rr` (reset 0): the selected requester is the first eligible index at or after `rr`, modulo `NUM_REQ`.
- On each issue, `rr` ← selected + 1 (wraps).

Issue FSM:
- IDLE: issue is allowed when any requester is eligible, the FIFO is not full and issue is not blocked.
  - Drive `apu_req_o` = 1 with the selected requester's payload.
  - `apu_gnt_i` = 1 → issue.
  - `apu_gnt_i` = 0 → latch the selection into `lock_sel` and go to HOLD.
- HOLD: drive `apu_req_o` = 1 with `lock_sel`'s payload regardless of other requesters.
  - Go back to IDLE on `apu_gnt_i`.
  - Requesters must hold valid and payload stable until ready; dropping valid in HOLD is a protocol violation (behaviour undefined).
- Issue = `apu_req_o` & `apu_gnt_i`.
  - `req_ready_o[sel]` = 1 in the issue cycle only (combinational from `apu_gnt_i`).
  - Push `{sel, req_divsqrt_i[sel]}` into the tag FIFO.

Tag FIFO:
- Push on issue; pop on `apu_rvalid_i`.
- Simultaneous push and pop leaves the count unchanged.
- Full (count = `DEPTH`) blocks issue, even if a pop occurs in the same cycle.
- Pointers wrap modulo `DEPTH`.

Response routing:
- `rsp_valid_o[head]` = `apu_rvalid_i`.
- `rsp_result_o` / `rsp_fflags_o` pass through combinationally.
- Zero-latency bypass: `apu_rvalid_i` in the issue cycle with an empty FIFO belongs to the issuing requester. No push and no pop occur.
- `apu_rvalid_i` with an empty FIFO and no issue: all `rsp_valid_o` = 0, and `err_o` is set until reset.

## Timing
- Reset (async assert, sync release): all outputs 0, FSM IDLE, `rr` = 0, FIFO empty, `err_o` = 0.
- Reset asserted mid-operation discards in-flight tags; results that arrive afterwards set `err_o`.
- Arbiter adds 0 cycles on both issue and response paths. All outputs are combinational from registered state and inputs, except `err_o`, which is registered.
- Maximum throughput: 1 issue per cycle while `apu_gnt_i` = 1 and the FIFO is not full.

## Configuration
- `FPU_ARB_DIVSQRT_SERIAL_EN` defined:
  - A div/sqrt op issues only when the FIFO is empty.
  - While it is in flight, all other issue is blocked; the block clears when its result pops.
  - Guarantees in-order completion with a variable-latency div/sqrt unit.
- Not defined: `req_divsqrt_i` is ignored, and the FPU is required to return results in issue order.

## Test plan
- Reset, then req0 and req1 valid together with `apu_gnt_i` = 1 every cycle → issue order req0, req1, req0, …
- Latency-2 FPU, results 0x3F800000 then 0x40000000 → `rsp_valid_o` = 01 then 10 with matching results; `busy_o` drops after the last pop.
- `apu_gnt_i` held low 3 cycles while req1 is granted-pending and req0 raises valid → `apu_op_o` stays on req1's op; req1 `ready` in the gnt cycle.
- `DEPTH` = 2, FPU never returns → exactly 2 issues, `apu_req_o` = 0 after; one `apu_rvalid_i` → third issue the next cycle.
- `FPU_ARB_DIVSQRT_SERIAL_EN`: req0 divsqrt with 5-cycle latency, req1 add pending → req1 issues only in the cycle after the div result.
- Spurious `apu_rvalid_i` with empty FIFO → no `rsp_valid_o`, `err_o` = 1 until `rst`.
